// File: rtl/mem_access_unit_if.sv
// ============================================================================
//  Module      : mem_access_unit_if
//  Description : Bundle of the request/response handshake between the MIPS
//                datapath and the load/store unit, plus the word-wide port
//                to the byte-addressed memory block.
//                  req_*  : one load/store request (valid/ready handshake)
//                  resp_* : one-cycle completion pulse with error and data
//                  mem_*  : aligned address, write enable, write/read data
//                Modport slave is the unit itself; master is its environment
//                (datapath driving requests and the memory returning mem_rd).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_access_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;

    modport slave (
        input  req_valid, req_write, req_size, req_unsigned, req_addr,
               req_wdata, mem_rd,
        output req_ready, resp_valid, resp_err, resp_rdata,
               mem_addr, mem_we, mem_wd
    );

    modport master (
        output req_valid, req_write, req_size, req_unsigned, req_addr,
               req_wdata, mem_rd,
        input  req_ready, resp_valid, resp_err, resp_rdata,
               mem_addr, mem_we, mem_wd
    );
endinterface

`default_nettype wire

// File: rtl/mem_access_unit.sv
// ============================================================================
//  Module      : mem_access_unit
//  Description : Load/store access unit. Accepts one byte/half/word request
//                at a time, sign- or zero-extends loads, performs sub-word
//                stores as read-modify-write of the aligned word, and flags
//                illegal sizes / misaligned accesses without touching memory.
//  Ports       : clk   - single clock, all state on posedge
//                reset - asynchronous, active-high
//                bus   - mem_access_unit_if.slave (request, response, memory)
//  Parameters  : CHECK_ALIGN - 1: misaligned half/word is an error,
//                              0: low address bits ignored
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_access_unit #(
    parameter int CHECK_ALIGN = 1
) (
    input  wire logic         clk,
    input  wire logic         reset,
    mem_access_unit_if.slave  bus
);

    localparam logic [1:0] c_SIZE_BYTE = 2'b00;
    localparam logic [1:0] c_SIZE_HALF = 2'b01;
    localparam logic [1:0] c_SIZE_WORD = 2'b10;
    localparam logic [1:0] c_SIZE_ILL  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic        r_write;
    logic [1:0]  r_size;
    logic        r_unsigned;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_wd;          // word to be written in WRITE
    logic        r_resp_err;
    logic [31:0] r_resp_rdata;

    logic        w_accept;
    logic        w_req_err;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load;
    logic [31:0] w_merge;

    // ------------------------------------------------------------------
    // Error decode on the live request (used only at acceptance)
    // ------------------------------------------------------------------
    always_comb begin
        w_req_err = 1'b0;
        if (bus.req_size == c_SIZE_ILL) begin
            w_req_err = 1'b1;
        end else if (CHECK_ALIGN != 0) begin
            if (bus.req_size == c_SIZE_HALF && bus.req_addr[0])
                w_req_err = 1'b1;
            if (bus.req_size == c_SIZE_WORD && bus.req_addr[1:0] != 2'b00)
                w_req_err = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Lane extraction / merge on the captured request and memory word
    // ------------------------------------------------------------------
    always_comb begin
        w_byte  = bus.mem_rd[{r_addr[1:0], 3'b000} +: 8];
        w_half  = bus.mem_rd[{r_addr[1], 4'b0000} +: 16];
        w_load  = bus.mem_rd;
        w_merge = bus.mem_rd;
        case (r_size)
            c_SIZE_BYTE: begin
                w_load = r_unsigned ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
                w_merge[{r_addr[1:0], 3'b000} +: 8] = r_wdata[7:0];
            end
            c_SIZE_HALF: begin
                w_load = r_unsigned ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
                w_merge[{r_addr[1], 4'b0000} +: 16] = r_wdata[15:0];
            end
            default: begin
                w_load  = bus.mem_rd;
                w_merge = bus.mem_rd;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // ------------------------------------------------------------------
    // FSM: next state and decoded outputs. Memory controls come purely
    // from state, so an asynchronous reset during WRITE drops mem_we
    // before the next edge.
    // ------------------------------------------------------------------
    always_comb begin
        w_next         = r_state;
        w_accept       = 1'b0;
        bus.req_ready  = 1'b0;
        bus.resp_valid = 1'b0;
        bus.mem_we     = 1'b0;
        bus.mem_addr   = 32'h0;
        bus.mem_wd     = 32'h0;
        case (r_state)
            S_IDLE: begin
                bus.req_ready = ~reset;
                w_accept      = bus.req_valid & ~reset;
                if (w_accept) begin
                    if (w_req_err)
                        w_next = S_RESP;
                    else if (bus.req_write && bus.req_size == c_SIZE_WORD)
                        w_next = S_WRITE;
                    else
                        w_next = S_READ;
                end
            end
            S_READ: begin
                bus.mem_addr = {r_addr[31:2], 2'b00};
                w_next       = r_write ? S_WRITE : S_RESP;
            end
            S_WRITE: begin
                bus.mem_addr = {r_addr[31:2], 2'b00};
                bus.mem_we   = 1'b1;
                bus.mem_wd   = r_wd;
                w_next       = S_RESP;
            end
            S_RESP: begin
                bus.resp_valid = 1'b1;
                w_next         = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Request capture and response registers. The response registers
    // change only on the edge entering RESP, so resp_rdata holds until
    // the next response.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_write      <= 1'b0;
            r_size       <= 2'b00;
            r_unsigned   <= 1'b0;
            r_addr       <= 32'h0;
            r_wdata      <= 32'h0;
            r_wd         <= 32'h0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= 32'h0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_write    <= bus.req_write;
                        r_size     <= bus.req_size;
                        r_unsigned <= bus.req_unsigned;
                        r_addr     <= bus.req_addr;
                        r_wdata    <= bus.req_wdata;
                        if (w_req_err) begin
                            r_resp_err   <= 1'b1;
                            r_resp_rdata <= 32'h0;
                        end else if (bus.req_write && bus.req_size == c_SIZE_WORD) begin
                            r_wd <= bus.req_wdata;
                        end
                    end
                end
                S_READ: begin
                    if (r_write) begin
                        r_wd <= w_merge;
                    end else begin
                        r_resp_err   <= 1'b0;
                        r_resp_rdata <= w_load;
                    end
                end
                S_WRITE: begin
                    r_resp_err   <= 1'b0;
                    r_resp_rdata <= 32'h0;
                end
                default: ;
            endcase
        end
    end

    assign bus.resp_err   = r_resp_err;
    assign bus.resp_rdata = r_resp_rdata;

endmodule

`default_nettype wire
